// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control core: holds A, D and PC, decodes A-/C-instructions,
// drives the external ALU and resolves memory writes and jumps.
module hack_cpu_ctrl #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [WIDTH-1:0]    instruction,
    input  logic [WIDTH-1:0]    inM,
    input  logic [WIDTH-1:0]    alu_out,
    input  logic                alu_zr,
    input  logic                alu_ng,
    output logic [WIDTH-1:0]    alu_x,
    output logic [WIDTH-1:0]    alu_y,
    output logic                alu_zx,
    output logic                alu_nx,
    output logic                alu_zy,
    output logic                alu_ny,
    output logic                alu_f,
    output logic                alu_no,
    output logic [WIDTH-1:0]    outM,
    output logic                writeM,
    output logic [WIDTH-1:0]    addressM,
    output logic [PC_WIDTH-1:0] pc
);

    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    d_reg;
    logic [PC_WIDTH-1:0] pc_reg;

    logic is_c;
    logic a_bit;
    logic dest_a;
    logic dest_d;
    logic dest_m;
    logic jump;

    // Bits 14:13 of a C-instruction carry no meaning in the Hack encoding.
    logic unused_bits;
    assign unused_bits = ^instruction[14:13];

    // Instruction decode and ALU / memory interface drive.
    always_comb begin
        is_c   = instruction[15];
        a_bit  = is_c & instruction[12];
        dest_a = is_c & instruction[5];
        dest_d = is_c & instruction[4];
        dest_m = is_c & instruction[3];
        jump   = is_c & ((instruction[2] & alu_ng) |
                         (instruction[1] & alu_zr) |
                         (instruction[0] & ~alu_zr & ~alu_ng));

        alu_x  = d_reg;
        alu_y  = a_bit ? inM : a_reg;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} =
            is_c ? instruction[11:6] : '0;

        outM     = alu_out;
        addressM = a_reg;
        writeM   = instr_valid & ~reset & dest_m;
        pc       = pc_reg;
    end

    // Register update: A, D and PC advance only on a valid instruction;
    // the jump target is taken from A before any dest-A write lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else if (instr_valid) begin
            if (!is_c) begin
                a_reg  <= instruction;
                pc_reg <= pc_reg + PC_WIDTH'(1);
            end else begin
                if (dest_a) a_reg <= alu_out;
                if (dest_d) d_reg <= alu_out;
                pc_reg <= jump ? a_reg[PC_WIDTH-1:0] : pc_reg + PC_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl with a behavioural Hack ALU attached.
module tb_hack_cpu_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] addressM;
    logic [15:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept by the bench.
    logic [15:0] m_a, m_d, m_pc;

    always #5 clock = ~clock;

    hack_cpu_ctrl #(.WIDTH(16), .PC_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid),
        .instruction(instruction), .inM(inM),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x_in,
                                             input logic [15:0] y_in,
                                             input logic [5:0]  c);
        logic [15:0] x, y, r;
        x = c[5] ? 16'h0000 : x_in;
        if (c[4]) x = ~x;
        y = c[3] ? 16'h0000 : y_in;
        if (c[2]) y = ~y;
        r = c[1] ? x + y : x & y;
        if (c[0]) r = ~r;
        return r;
    endfunction

    // The ALU the control core is wired to.
    always_comb begin
        alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive, check combinational outputs mid-cycle
    // against the model, advance the model, check registers after the edge.
    task automatic apply(input logic rst, input logic v,
                         input logic [15:0] ins, input logic [15:0] im,
                         output logic wm_s, output logic [15:0] out_s,
                         output logic [15:0] addr_s);
        logic        is_c, jump;
        logic [15:0] y, r;
        reset = rst; instr_valid = v; instruction = ins; inM = im;
        is_c = ins[15];
        y = (is_c && ins[12]) ? im : m_a;
        r = hack_alu(m_d, y, is_c ? ins[11:6] : 6'b0);
        @(negedge clock);
        wm_s = writeM; out_s = outM; addr_s = addressM;
        chk("writeM", writeM, v && !rst && is_c && ins[3]);
        chk("addressM", addressM, m_a);
        chk("alu_x", alu_x, m_d);
        chk("alu_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
            is_c ? ins[11:6] : 6'b0);
        if (is_c) begin
            chk("alu_y", alu_y, y);
            chk("outM", outM, r);
        end
        if (rst) begin
            m_a = 0; m_d = 0; m_pc = 0;
        end else if (v) begin
            if (!is_c) begin
                m_a  = ins;
                m_pc = m_pc + 16'd1;
            end else begin
                jump = (ins[2] && $signed(r) < 0) || (ins[1] && r == 0) ||
                       (ins[0] && $signed(r) > 0);
                m_pc = jump ? m_a : m_pc + 16'd1;
                if (ins[5]) m_a = r;
                if (ins[4]) m_d = r;
            end
        end
        @(posedge clock);
        #1;
        chk("pc", pc, m_pc);
        chk("A", addressM, m_a);
        chk("D", alu_x, m_d);
    endtask

    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] ins;
        logic [15:0] im;
        logic        wm;
        logic [15:0] outm;
        logic        chk_out;
        logic [15:0] addr;
        logic [15:0] pc_n;
        logic [15:0] a_n;
        logic [15:0] d_n;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic        wm_s;
        logic [15:0] out_s, addr_s;

        // rst v   ins       inM    wm  outM     chk addr     pc       A        D
        tbl[0]  = '{0, 1, 16'h0005, 16'd0,  0, 16'h0000, 0, 16'h0000, 16'h0001, 16'h0005, 16'h0000};
        tbl[1]  = '{0, 1, 16'hEC10, 16'd0,  0, 16'h0005, 1, 16'h0005, 16'h0002, 16'h0005, 16'h0005};
        tbl[2]  = '{0, 1, 16'hE308, 16'd0,  1, 16'h0005, 1, 16'h0005, 16'h0003, 16'h0005, 16'h0005};
        tbl[3]  = '{0, 1, 16'h0010, 16'd0,  0, 16'h0000, 0, 16'h0005, 16'h0004, 16'h0010, 16'h0005};
        tbl[4]  = '{0, 1, 16'hEA87, 16'd0,  0, 16'h0000, 1, 16'h0010, 16'h0010, 16'h0010, 16'h0005};
        tbl[5]  = '{0, 1, 16'hEA90, 16'd0,  0, 16'h0000, 1, 16'h0010, 16'h0011, 16'h0010, 16'h0000};
        tbl[6]  = '{0, 1, 16'hE301, 16'd0,  0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h0010, 16'h0000};
        tbl[7]  = '{0, 1, 16'h0007, 16'd0,  0, 16'h0000, 0, 16'h0010, 16'h0013, 16'h0007, 16'h0000};
        tbl[8]  = '{0, 1, 16'hFDE8, 16'd41, 1, 16'd42,   1, 16'h0007, 16'h0014, 16'd42,   16'h0000};
        tbl[9]  = '{0, 0, 16'hE308, 16'd0,  0, 16'h0000, 1, 16'd42,   16'h0014, 16'd42,   16'h0000};
        tbl[10] = '{0, 0, 16'hE308, 16'd0,  0, 16'h0000, 1, 16'd42,   16'h0014, 16'd42,   16'h0000};
        tbl[11] = '{0, 0, 16'hE308, 16'd0,  0, 16'h0000, 1, 16'd42,   16'h0014, 16'd42,   16'h0000};
        tbl[12] = '{0, 0, 16'hE308, 16'd0,  0, 16'h0000, 1, 16'd42,   16'h0014, 16'd42,   16'h0000};
        tbl[13] = '{0, 1, 16'h0020, 16'd0,  0, 16'h0000, 0, 16'd42,   16'h0015, 16'h0020, 16'h0000};
        tbl[14] = '{0, 1, 16'hEC10, 16'd0,  0, 16'h0020, 1, 16'h0020, 16'h0016, 16'h0020, 16'h0020};
        tbl[15] = '{0, 1, 16'hEAA7, 16'd0,  0, 16'h0000, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0020};
        tbl[16] = '{1, 1, 16'hE308, 16'd0,  0, 16'h0020, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[17] = '{0, 1, 16'hEEA0, 16'd0,  0, 16'hFFFF, 1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
        tbl[18] = '{0, 1, 16'hEA87, 16'd0,  0, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        tbl[19] = '{0, 1, 16'h0003, 16'd0,  0, 16'h0000, 0, 16'hFFFF, 16'h0000, 16'h0003, 16'h0000};

        // Initial reset with a memory-write C-instruction present.
        reset = 1'b1; instr_valid = 1'b1; instruction = 16'hE308; inM = 16'h1234;
        @(posedge clock);
        @(negedge clock);
        chk("writeM_in_reset", writeM, 1'b0);
        @(posedge clock);
        #1;
        m_a = 0; m_d = 0; m_pc = 0;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_A", addressM, 16'h0000);
        chk("reset_D", alu_x, 16'h0000);

        // Directed program from the test plan.
        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].rst, tbl[i].v, tbl[i].ins, tbl[i].im, wm_s, out_s, addr_s);
            chk($sformatf("tbl%0d_writeM", i), wm_s, tbl[i].wm);
            chk($sformatf("tbl%0d_addressM", i), addr_s, tbl[i].addr);
            if (tbl[i].chk_out) chk($sformatf("tbl%0d_outM", i), out_s, tbl[i].outm);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc_n);
            chk($sformatf("tbl%0d_A", i), addressM, tbl[i].a_n);
            chk($sformatf("tbl%0d_D", i), alu_x, tbl[i].d_n);
        end

        // Randomised run against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(49, 0) == 0, $urandom_range(9, 0) != 0,
                  16'($urandom), 16'($urandom), wm_s, out_s, addr_s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Hack CPU control and datapath core that issues operands and control bits to the ALU and consumes its results.
- Drives the existing 16-bit ALU's x, y and zx/nx/zy/ny/f/no inputs, and takes back out, zr and ng.
- Holds the A register, D register and PC.
- Decodes Hack A- and C-instructions, generates memory write strobes, and resolves jumps.
- Sits between instruction ROM / data RAM and the ALU instance; the CPU top level instantiates both.

Parameters:
- WIDTH, 16, data/A/D/instruction width; only 16 is supported by the Hack encoding.
- PC_WIDTH, 16, program counter width; wraps modulo 2^PC_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; A, D and PC cleared on the edge where it is high.
- instr_valid  in  1  instruction valid. When 0, the core stalls: no state change, writeM forced 0.
- instruction  in  16  current instruction from ROM at address pc.
- inM  in  16  data RAM read value at addressM.
- alu_out  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- alu_x  out  16  ALU x operand (= D).
- alu_y  out  16  ALU y operand (= inM if the a-bit is 1, else A).
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
- outM  out  16  RAM write data (= alu_out).
- writeM  out  1  RAM write enable.
- addressM  out  16  RAM address (= current A).
- pc  out  PC_WIDTH  ROM address of the next instruction to fetch.

Behaviour:
- Reset:
  - A = 0, D = 0, pc = 0 after the edge with reset high.
  - writeM is 0 while reset is high.
  - Reset overrides instr_valid and any in-flight instruction; a mid-program reset restarts at pc = 0.
- Decode (combinational, same cycle as instruction):
  - instruction[15] = 0: A-instruction.
  - instruction[15] = 1: C-instruction; bits 14:13 are ignored.
  - C fields:
    - a = bit 12.
    - c1..c6 = bits 11..6, mapped to zx, nx, zy, ny, f, no.
    - d1 = bit 5 (dest A), d2 = bit 4 (dest D), d3 = bit 3 (dest M).
    - j1 = bit 2 (out < 0), j2 = bit 1 (out = 0), j3 = bit 0 (out > 0).
- ALU drive:
  - alu_x = D and alu_y = a ? inM : A, always driven.
  - Control bits are driven from bits 11..6 for C-instructions and forced to 0 for A-instructions.
- Combinational outputs:
  - writeM = instr_valid & ~reset & C & d3.
  - outM = alu_out.
  - addressM = current (pre-update) A.
- A-instruction, valid, on the clock edge: A <= instruction; pc <= pc + 1; D unchanged.
- C-instruction, valid, on the clock edge:
  - if d1: A <= alu_out.
  - if d2: D <= alu_out.
  - jump = (j1 & alu_ng) | (j2 & alu_zr) | (j3 & ~alu_zr & ~alu_ng).
  - pc <= jump ? A_old[PC_WIDTH-1:0] : pc + 1.
- Simultaneous events:
  - dest A plus a jump: the jump target is the old A.
  - dest A plus dest M: addressM is the old A.
  - dest A and D together: both get the same alu_out.
- Stall: instr_valid = 0 holds A, D and pc, and keeps writeM at 0. ALU outputs are still driven.
- Wrap: pc + 1 wraps from 2^PC_WIDTH - 1 to 0 with no flag.
- Latency:
  - Register results are visible one cycle after the instruction.
  - writeM, outM and addressM are valid in the same cycle as the instruction.

Test Plan (bench instantiates hack_cpu_ctrl wired to the existing ALU):
- Reset mid-run:
  - Run 3 instructions, then assert reset for 1 cycle.
  - Required: pc = 0, A = 0, D = 0 next cycle; writeM = 0 during reset.
- Load and move:
  - 0x0005 (@5), then 0xEC10 (D=A).
  - Required: A = 5 and pc = 1 after cycle 1; D = 5 and pc = 2 after cycle 2.
- Memory write:
  - With D = 5, A = 5, issue 0xE308 (M=D).
  - Required: writeM = 1, outM = 5, addressM = 5 in that cycle; A and D unchanged.
- Jumps:
  - 0x0010 (@16), then 0xEA87 (0;JMP): pc = 16.
  - With D = 0, 0xE301 (D;JGT): no jump, pc increments.
- Old-A rule:
  - A = 7, inM = 41, issue 0xFDE8 (AM=M+1).
  - Required: addressM = 7, outM = 42, writeM = 1; A = 42 next cycle.
- Stall and wrap:
  - instr_valid = 0 for 4 cycles with 0xE308 present: pc, A and D held, writeM = 0.
  - pc = 0xFFFF with an A-instruction: pc becomes 0.
